// File: rtl/rca_64bit.sv
// rca_64bit: 64-bit ripple-carry adder with registered sum and carry-out
// ports: clk, rst (sync active-high, clears outputs), a/b 64-bit operands, cin carry into bit 0,
//        sum registered a+b+cin mod 2^64, cout registered carry out of bit 63
module rca_64bit (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);
   logic [63:0] s;
   logic        c;
   // carry ripples serially through all 64 full adders; c ends as the carry out of bit 63
   always_comb begin
      s = '0;
      c = cin;
      for (int k = 0; k < 64; k++) begin
         s[k] = a[k] ^ b[k] ^ c;
         c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
      end
   end
   always_ff @(posedge clk) begin
      sum  <= rst ? '0 : s;
      cout <= rst ? 1'b0 : c;
   end
endmodule

// File: tb/tb_rca_64bit.sv
// tb_rca_64bit: directed self-checking bench for rca_64bit
module tb_rca_64bit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        cin = 1'b0;
   logic [63:0] sum;
   logic        cout;
   int checks = 0;
   int failures = 0;

   rca_64bit dut (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout));

   always #10 clk = ~clk;

   task automatic step(input logic r, input logic [63:0] av, input logic [63:0] bv, input logic ci);
      @(negedge clk);
      rst = r;
      a   = av;
      b   = bv;
      cin = ci;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] se, input logic ce);
      checks++;
      assert ({cout, sum} === {ce, se})
      else begin
         failures++;
         $error("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h", tag, cout, sum, ce, se);
      end
   endtask

   initial begin
      step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
      chk("reset_c1", 64'h0, 1'b0);
      step(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
      chk("reset_c2", 64'h0, 1'b0);
      step(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
      chk("release", 64'hFFFFFFFFFFFFFFFF, 1'b1);
      step(1'b0, 64'h3EB1E0033EBF3EBF, 64'h5555555555555555, 1'b0);
      chk("mixed", 64'h9407355894149414, 1'b0);
      step(1'b0, 64'h3EBF3EBF3EBF3EBF, 64'h557F5001555F1015, 1'b0);
      chk("partial", 64'h943E8EC0941E4ED4, 1'b0);
      step(1'b0, 64'hBEBFF81FAA1DD117, 64'h527252C555555555, 1'b0);
      chk("carry_out", 64'h11324AE4FF73266C, 1'b1);
      step(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
      chk("ripple_cin", 64'h0, 1'b1);
      step(1'b0, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0);
      chk("ripple_msb", 64'h8000000000000000, 1'b0);
      step(1'b0, 64'h3EB1E0033EBF3EBF, 64'h5555555555555555, 1'b0);
      chk("b2b_1", 64'h9407355894149414, 1'b0);
      step(1'b0, 64'h3EBF3EBF3EBF3EBF, 64'h557F5001555F1015, 1'b0);
      chk("b2b_2", 64'h943E8EC0941E4ED4, 1'b0);
      step(1'b0, 64'hBEBFF81FAA1DD117, 64'h527252C555555555, 1'b0);
      chk("b2b_3", 64'h11324AE4FF73266C, 1'b1);
      step(1'b0, 64'h3EB1E0033EBF3EBF, 64'h5555555555555555, 1'b0);
      chk("mid_1", 64'h9407355894149414, 1'b0);
      step(1'b1, 64'h3EBF3EBF3EBF3EBF, 64'h557F5001555F1015, 1'b0);
      chk("mid_rst", 64'h0, 1'b0);
      step(1'b0, 64'hBEBFF81FAA1DD117, 64'h527252C555555555, 1'b0);
      chk("mid_3", 64'h11324AE4FF73266C, 1'b1);
      step(1'b0, 64'h0, 64'h0, 1'b0);
      chk("zero", 64'h0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
